mult_seq_arbiter: RTL and testbench
===================================

// Module: mult_seq_arbiter
// PURPOSE
//  Shares one sequential shift-and-add multiplier between two requesters.
//  Round-robin arbitration; one operation in flight. Fixed-latency WIDTH-cycle iteration.
//  Responses return with the requester ID. Sits between the operand sources and the product consumer.
// PARAMETERS
//  WIDTH  4  operand width in bits; product is 2*WIDTH bits
// PORTS
//  clk        in   1        clock, rising edge
//  rst_n      in   1        reset, asynchronous, active-low
//  req_valid  in   2        per-requester operand valid
//  req_ready  out  2        per-requester accept; one-hot or zero
//  req_m      in   2*WIDTH  multiplicands; requester i at [i*WIDTH +: WIDTH]
//  req_q      in   2*WIDTH  multipliers, same packing
//  rsp_valid  out  1        result valid
//  rsp_ready  in   1        consumer accept
//  rsp_id     out  1        requester that owns rsp_p
//  rsp_p      out  2*WIDTH  product (or running sum, see CONFIGURATION)
//  busy       out  1        high in RUN or DONE
// BEHAVIOUR
//  Reset: state=IDLE; rsp_valid=0, rsp_id=0, rsp_p=0, busy=0, req_ready=0.
//   last_grant=1, so requester 0 wins the first contest.
//  FSM IDLE -> RUN -> DONE -> IDLE.
//  IDLE: req_ready is combinational and goes only to the arbiter winner.
//   Winner: the non-last requester if valid, else the other if valid.
//   Transfer on req_valid&req_ready.
//   Then capture m, q and id; set acc=0, cnt=0; go to RUN.
//  RUN: each cycle, if q_sh[0] then acc+=m_sh; m_sh<<=1; q_sh>>=1; cnt++.
//   After exactly WIDTH cycles go to DONE. No early exit on zero operands.
//  DONE: rsp_valid=1. rsp_p/rsp_id stay stable until rsp_valid&rsp_ready.
//   On that handshake: go to IDLE, last_grant=rsp_id.
//   A new accept happens at the earliest on the next cycle (no same-cycle turnaround).
//  Latency: accept at edge N -> rsp_valid high after edge N+WIDTH+1.
//  req_ready=0 in RUN/DONE. Input changes while not accepted are ignored.
//  Arithmetic: acc is 2*WIDTH bits. Max (2^W-1)^2 cannot overflow.
//  Reset mid-operation: abort immediately, return to reset values, no response.
//  A requester dropping valid before acceptance is legal; it simply loses the slot.
// CONFIGURATION
//  MULT_ACCUM_EN defined:
//   - Adds port acc_clr in 2: per-requester synchronous clear.
//   - Adds two 2*WIDTH accumulators, reset to 0.
//   - In DONE, on entry, the owner's accumulator += product, wrapping mod 2^(2W).
//     rsp_p returns the new sum.
//   - acc_clr[i] in the same cycle as the update: result = product only.
//   - acc_clr[i] otherwise: accumulator -> 0.
//  MULT_ACCUM_EN undefined: no acc_clr port, no accumulators; rsp_p = product.
// STRUCTURE
//  Package mult_seq_pkg:
//   - state enum {IDLE,RUN,DONE}
//   - WIDTH_DEF=4
//   - req_id_t (1 bit)
//   - CNT_W=$clog2(WIDTH+1)
//  Sub-module rr_arb2: 2-way round-robin.
//   Inputs: req[1:0], last, en. Output: gnt[1:0], one-hot or zero.
//  Datapath and FSM stay in this module.
// TESTING (WIDTH=4)
//  1. Reset, req0 m=3 q=5 -> req_ready[0] same cycle; rsp_valid 5 cycles later; p=15, id=0.
//  2. Both valid, (15,15) and (2,7) -> id0 p=225 first, then id1 p=14; next tie goes to req0.
//  3. rsp_ready low for 10 cycles in DONE -> rsp_p/rsp_id stable, req_ready=00, busy=1.
//  4. m=0 q=9 and m=9 q=0 -> p=0, latency still 5 cycles.
//  5. rst_n low during RUN -> rsp_valid=0, busy=0 asynchronously; next contest won by req0.
//  6. MULT_ACCUM_EN: req0 3x5 then 2x2 -> 15, 19.
//     acc_clr[0] pulse, then 1x1 -> 1. Requester 1 sum unaffected.

Source files
------------

// File: rtl/mult_seq_pkg.sv
// Shared types and sizing for the round-robin sequential multiplier arbiter.
// Latency/backpressure: n/a (declarations only).
package mult_seq_pkg;

   localparam int WIDTH_DEF = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   typedef logic req_id_t;

   // Counter must reach WIDTH itself, hence WIDTH+1 states.
   function automatic int cnt_w(input int w);
      return $clog2(w + 1);
   endfunction

   localparam int CNT_W = cnt_w(WIDTH_DEF);

endpackage

// File: rtl/mult_seq_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: the requester that was not served last wins a tie.
// Latency: purely combinational; grants nothing while en is low.
module rr_arb2
   import mult_seq_pkg::*;
(
   input  logic [1:0] req,
   input  req_id_t    last,
   input  logic       en,
   output logic [1:0] gnt
);

   always_comb begin
      gnt = 2'b00;
      if (en) begin
         if (last == 1'b1) begin
            if (req[0])      gnt = 2'b01;
            else if (req[1]) gnt = 2'b10;
         end else begin
            if (req[1])      gnt = 2'b10;
            else if (req[0]) gnt = 2'b01;
         end
      end
   end

endmodule

// File: rtl/mult_seq_arbiter.sv
// One shift-and-add multiplier shared by two requesters; optional per-requester accumulate (MULT_ACCUM_EN).
// Accept at edge N -> rsp_valid after edge N+WIDTH+1; one op in flight, result held until rsp_ready.
module mult_seq_arbiter
   import mult_seq_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [1:0]         req_valid,
   output logic [1:0]         req_ready,
   input  logic [2*WIDTH-1:0] req_m,
   input  logic [2*WIDTH-1:0] req_q,
`ifdef MULT_ACCUM_EN
   input  logic [1:0]         acc_clr,
`endif
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic               rsp_id,
   output logic [2*WIDTH-1:0] rsp_p,
   output logic               busy
);

   localparam int PW       = 2 * WIDTH;
   localparam int CNT_BITS = cnt_w(WIDTH);

   state_t              state_q, state_d;
   req_id_t             last_grant_q, last_grant_d;
   req_id_t             id_q, id_d;
   logic [PW-1:0]       m_sh_q, m_sh_d;
   logic [WIDTH-1:0]    q_sh_q, q_sh_d;
   logic [PW-1:0]       acc_q, acc_d;
   logic [CNT_BITS-1:0] cnt_q, cnt_d;
   logic [PW-1:0]       rsp_p_q, rsp_p_d;

   logic [1:0]          gnt;
   logic                accept;
   logic                finish;
   logic                rsp_hs;
   logic [WIDTH-1:0]    win_m;
   logic [WIDTH-1:0]    win_q;
   logic [PW-1:0]       result;

   rr_arb2 u_arb (
      .req  (req_valid),
      .last (last_grant_q),
      .en   (state_q == IDLE),
      .gnt  (gnt)
   );

   assign accept = |(req_valid & gnt);
   assign win_m  = gnt[1] ? req_m[PW-1:WIDTH] : req_m[WIDTH-1:0];
   assign win_q  = gnt[1] ? req_q[PW-1:WIDTH] : req_q[WIDTH-1:0];
   // WIDTH iterations, then one cycle to latch the (possibly accumulated) result.
   assign finish = (state_q == RUN) && (cnt_q == CNT_BITS'(WIDTH));
   assign rsp_hs = (state_q == DONE) && rsp_ready;

`ifdef MULT_ACCUM_EN
   logic [1:0][PW-1:0] accum_q, accum_d;
   logic [PW-1:0]      accum_base;

   // A clear coinciding with the update restarts the sum at this product.
   always_comb begin
      accum_base = acc_clr[id_q] ? '0 : accum_q[id_q];
      result     = accum_base + acc_q;
      for (int i = 0; i < 2; i++) begin
         accum_d[i] = acc_clr[i] ? '0 : accum_q[i];
      end
      if (finish) begin
         accum_d[id_q] = result;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         accum_q <= '0;
      end else begin
         accum_q <= accum_d;
      end
   end
`else
   assign result = acc_q;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = RUN;
         RUN:     if (finish) state_d = DONE;
         DONE:    if (rsp_hs) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      req_ready = gnt;
      rsp_valid = (state_q == DONE);
      busy      = (state_q != IDLE);
      rsp_id    = id_q;
      rsp_p     = rsp_p_q;
   end

   always_comb begin
      last_grant_d = last_grant_q;
      id_d         = id_q;
      m_sh_d       = m_sh_q;
      q_sh_d       = q_sh_q;
      acc_d        = acc_q;
      cnt_d        = cnt_q;
      rsp_p_d      = rsp_p_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               id_d   = gnt[1];
               m_sh_d = {{WIDTH{1'b0}}, win_m};
               q_sh_d = win_q;
               acc_d  = '0;
               cnt_d  = '0;
            end
         end
         RUN: begin
            if (finish) begin
               rsp_p_d = result;
            end else begin
               if (q_sh_q[0]) begin
                  acc_d = acc_q + m_sh_q;
               end
               m_sh_d = m_sh_q << 1;
               q_sh_d = q_sh_q >> 1;
               cnt_d  = cnt_q + CNT_BITS'(1);
            end
         end
         DONE: begin
            if (rsp_hs) begin
               last_grant_d = id_q;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_grant_q <= 1'b1;
         id_q         <= 1'b0;
         m_sh_q       <= '0;
         q_sh_q       <= '0;
         acc_q        <= '0;
         cnt_q        <= '0;
         rsp_p_q      <= '0;
      end else begin
         last_grant_q <= last_grant_d;
         id_q         <= id_d;
         m_sh_q       <= m_sh_d;
         q_sh_q       <= q_sh_d;
         acc_q        <= acc_d;
         cnt_q        <= cnt_d;
         rsp_p_q      <= rsp_p_d;
      end
   end

endmodule

// File: tb/tb_mult_seq_arbiter.sv
// Directed bench for mult_seq_arbiter (WIDTH=4); accumulate checks only when MULT_ACCUM_EN is defined.
module tb_mult_seq_arbiter;

   logic       clk;
   logic       rst_n;
   logic [1:0] req_valid;
   logic [1:0] req_ready;
   logic [7:0] req_m;
   logic [7:0] req_q;
   logic       rsp_valid;
   logic       rsp_ready;
   logic       rsp_id;
   logic [7:0] rsp_p;
   logic       busy;
`ifdef MULT_ACCUM_EN
   logic [1:0] acc_clr;
`endif

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [1:0] vld;
      logic [3:0] m0;
      logic [3:0] q0;
      logic [3:0] m1;
      logic [3:0] q1;
      logic [1:0] gnt;
      logic [7:0] p;
      logic       id;
   } vec_t;

   vec_t tbl [8];

   mult_seq_arbiter #(.WIDTH(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_m     (req_m),
      .req_q     (req_q),
`ifdef MULT_ACCUM_EN
      .acc_clr   (acc_clr),
`endif
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_p     (rsp_p),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic wait_rsp(output int lat);
      lat = 0;
      while (rsp_valid !== 1'b1 && lat < 20) begin
         tick();
         lat++;
      end
   endtask

   // Present operands, check the grant, let it be accepted, then check latency and result.
   task automatic do_op(input string name, input logic [1:0] vld,
                        input logic [3:0] m0, input logic [3:0] q0,
                        input logic [3:0] m1, input logic [3:0] q1,
                        input logic [1:0] exp_gnt, input logic [7:0] exp_p,
                        input logic exp_id);
      int lat;
      req_valid = vld;
      req_m     = {m1, m0};
      req_q     = {q1, q0};
      #1;
      chk({name, "_gnt"}, 32'(req_ready), 32'(exp_gnt));
      tick();
      req_valid = 2'b00;
      req_m     = 8'hFF;
      req_q     = 8'hFF;
      wait_rsp(lat);
      chk({name, "_lat"}, 32'(lat), 32'd5);
      chk({name, "_id"}, 32'(rsp_id), 32'(exp_id));
      chk({name, "_p"}, 32'(rsp_p), 32'(exp_p));
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      #1;
      chk({name, "_vld_drop"}, 32'(rsp_valid), 32'd0);
   endtask

   initial begin
      int lat;

      tbl[0] = '{2'b01, 4'd3,  4'd5,  4'd0,  4'd0, 2'b01, 8'd15,  1'b0};
      tbl[1] = '{2'b10, 4'd0,  4'd0,  4'd9,  4'd0, 2'b10, 8'd0,   1'b1};
      tbl[2] = '{2'b01, 4'd0,  4'd9,  4'd0,  4'd0, 2'b01, 8'd0,   1'b0};
      tbl[3] = '{2'b10, 4'd0,  4'd0,  4'd15, 4'd1, 2'b10, 8'd15,  1'b1};
      tbl[4] = '{2'b11, 4'd1,  4'd15, 4'd4,  4'd4, 2'b01, 8'd15,  1'b0};
      tbl[5] = '{2'b11, 4'd2,  4'd2,  4'd4,  4'd4, 2'b10, 8'd16,  1'b1};
      tbl[6] = '{2'b01, 4'd15, 4'd15, 4'd0,  4'd0, 2'b01, 8'd225, 1'b0};
      tbl[7] = '{2'b10, 4'd0,  4'd0,  4'd5,  4'd3, 2'b10, 8'd15,  1'b1};

      rst_n     = 1'b0;
      req_valid = 2'b00;
      req_m     = 8'h00;
      req_q     = 8'h00;
      rsp_ready = 1'b0;
`ifdef MULT_ACCUM_EN
      acc_clr   = 2'b11;
`endif
      tick();
      tick();
      chk("rst_vld",   32'(rsp_valid), 32'd0);
      chk("rst_id",    32'(rsp_id),    32'd0);
      chk("rst_p",     32'(rsp_p),     32'd0);
      chk("rst_busy",  32'(busy),      32'd0);
      chk("rst_ready", 32'(req_ready), 32'd0);
      rst_n = 1'b1;
      tick();

      for (int i = 0; i < 8; i++) begin
         do_op($sformatf("vec%0d", i), tbl[i].vld, tbl[i].m0, tbl[i].q0,
               tbl[i].m1, tbl[i].q1, tbl[i].gnt, tbl[i].p, tbl[i].id);
      end

      // Both requesters waiting: alternate service, then req0 wins the next tie.
      req_valid = 2'b11;
      req_m     = {4'd2, 4'd15};
      req_q     = {4'd7, 4'd15};
      #1;
      chk("rr_first_gnt", 32'(req_ready), 32'b01);
      tick();
      wait_rsp(lat);
      chk("rr_first_lat", 32'(lat), 32'd5);
      chk("rr_first_id",  32'(rsp_id), 32'd0);
      chk("rr_first_p",   32'(rsp_p), 32'd225);
      rsp_ready = 1'b1;
      #1;
      chk("rr_no_turnaround", 32'(req_ready), 32'b00);
      tick();
      rsp_ready = 1'b0;
      #1;
      chk("rr_second_gnt", 32'(req_ready), 32'b10);
      tick();
      wait_rsp(lat);
      chk("rr_second_id", 32'(rsp_id), 32'd1);
      chk("rr_second_p",  32'(rsp_p), 32'd14);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      #1;
      chk("rr_tie_gnt", 32'(req_ready), 32'b01);
      req_valid = 2'b00;
      tick();

      // Consumer stalls in DONE while requester 1 keeps asking and requester 0 changes its operands.
      req_valid = 2'b11;
      req_m     = {4'd1, 4'd7};
      req_q     = {4'd1, 4'd3};
      #1;
      chk("stall_gnt", 32'(req_ready), 32'b01);
      tick();
      req_valid = 2'b10;
      req_m     = {4'd1, 4'd12};
      wait_rsp(lat);
      chk("stall_lat", 32'(lat), 32'd5);
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("stall_vld",   32'(rsp_valid), 32'd1);
         chk("stall_p",     32'(rsp_p),     32'd21);
         chk("stall_id",    32'(rsp_id),    32'd0);
         chk("stall_ready", 32'(req_ready), 32'b00);
         chk("stall_busy",  32'(busy),      32'd1);
      end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      req_valid = 2'b00;
      tick();

      // Reset during RUN aborts the operation and restores the initial round-robin priority.
      req_valid = 2'b11;
      req_m     = {4'd3, 4'd3};
      req_q     = {4'd3, 4'd3};
      #1;
      chk("abort_gnt", 32'(req_ready), 32'b10);
      tick();
      req_valid = 2'b00;
      tick();
      tick();
      chk("abort_busy_pre", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("abort_busy", 32'(busy),      32'd0);
      chk("abort_vld",  32'(rsp_valid), 32'd0);
      chk("abort_p",    32'(rsp_p),     32'd0);
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) tick();
      chk("abort_no_rsp", 32'(rsp_valid), 32'd0);
      do_op("abort_next", 2'b11, 4'd6, 4'd6, 4'd1, 4'd1, 2'b01, 8'd36, 1'b0);

`ifdef MULT_ACCUM_EN
      acc_clr = 2'b00;
      do_op("acc_a", 2'b01, 4'd3, 4'd5, 4'd0, 4'd0, 2'b01, 8'd15, 1'b0);
      do_op("acc_b", 2'b01, 4'd2, 4'd2, 4'd0, 4'd0, 2'b01, 8'd19, 1'b0);
      do_op("acc_c", 2'b10, 4'd0, 4'd0, 4'd2, 4'd3, 2'b10, 8'd6,  1'b1);
      acc_clr = 2'b01;
      tick();
      acc_clr = 2'b00;
      do_op("acc_d", 2'b01, 4'd1, 4'd1, 4'd0, 4'd0, 2'b01, 8'd1,  1'b0);
      do_op("acc_e", 2'b10, 4'd0, 4'd0, 4'd1, 4'd1, 2'b10, 8'd7,  1'b1);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
